// File: rtl/structures.sv
// Shared types for the memory-side datapath.
// mem_store_type_t : store command presented to data_mem (NO_STORE when idle)
// mem_size_t       : access size of a load/store request (2'b01 is reserved)
// lsu_state_t      : lsu_port control states
package structures;

  typedef enum logic [1:0] {
    NO_STORE    = 2'b00,
    STORE_BYTE  = 2'b01,
    STORE_WORD  = 2'b10,
    STORE_DWORD = 2'b11
  } mem_store_type_t;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } lsu_state_t;

  // True when the size encoding is defined and the address is naturally aligned for it.
  function automatic logic size_aligned(input mem_size_t size, input logic [2:0] addr_lo);
    logic ok;
    case (size)
      SIZE_BYTE:  ok = 1'b1;
      SIZE_WORD:  ok = (addr_lo[1:0] == 2'b00);
      SIZE_DWORD: ok = (addr_lo == 3'b000);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic mem_store_type_t store_type_of(input mem_size_t size);
    mem_store_type_t st;
    case (size)
      SIZE_BYTE:  st = STORE_BYTE;
      SIZE_WORD:  st = STORE_WORD;
      SIZE_DWORD: st = STORE_DWORD;
      default:    st = NO_STORE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/lsu_port_load_extend.sv
// load_extend: picks the addressed byte/word/dword out of a 64-bit memory word and
// sign- or zero-extends it to 64 bits. Purely combinational.
//   rdata    : raw 64-bit word from data memory
//   addr_lo  : byte offset within the word
//   size     : access size
//   zero_ext : 1 = zero-extend, 0 = sign-extend (ignored for dwords)
//   result   : extended load data
module load_extend
  import structures::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  addr_lo,
  input  mem_size_t   size,
  input  logic        zero_ext,
  output logic [63:0] result
);

  logic [7:0]  byte_sel;
  logic [31:0] word_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    word_sel = addr_lo[2] ? rdata[63:32] : rdata[31:0];
    case (size)
      SIZE_BYTE:  result = {{56{~zero_ext & byte_sel[7]}}, byte_sel};
      SIZE_WORD:  result = {{32{~zero_ext & word_sel[31]}}, word_sel};
      SIZE_DWORD: result = rdata;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_port.sv
// lsu_port: single-outstanding load/store initiator between the MEM stage and data_mem.
//   req_*          : request channel (valid/ready), sampled only at the accept edge
//   resp_*         : response channel (valid/ready); rdata is extended load data, 0 otherwise
//   mem_*          : data-side port of data_mem; a store is presented only during ISSUE
//   fault_count    : saturating count of faulted requests
// Illegal requests (reserved size, misaligned, out of range) skip memory and answer with
// resp_fault one cycle after accept; legal ones spend one ISSUE cycle first.
module lsu_port
  import structures::*;
#(
  parameter int unsigned data_words = 'h4000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  mem_size_t       req_size,
  input  logic            req_unsigned,
  input  logic [63:0]     req_addr,
  input  logic [63:0]     req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [63:0]     resp_rdata,
  output logic            resp_fault,
  output logic [63:0]     mem_addr,
  output logic [63:0]     mem_wdata,
  output mem_store_type_t mem_store_type,
  input  logic [63:0]     mem_rdata,
  output logic [15:0]     fault_count
);

  localparam logic [63:0] AddrLimit = {32'd0, data_words} << 3;

  lsu_state_t  state_q, state_d;
  logic        is_store_q;
  mem_size_t   size_q;
  logic        zero_ext_q;
  logic [63:0] mem_addr_q, mem_wdata_q;
  logic [63:0] resp_rdata_q;
  logic        resp_fault_q;
  logic [15:0] fault_count_q;
  logic        accept;
  logic        req_legal;
  logic [63:0] ext_data;

  load_extend u_load_extend (
    .rdata    (mem_rdata),
    .addr_lo  (mem_addr_q[2:0]),
    .size     (size_q),
    .zero_ext (zero_ext_q),
    .result   (ext_data)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      RESP:    req_ready = resp_ready;
      default: req_ready = 1'b0;
    endcase
    accept    = req_valid & req_ready;
    // Full 64-bit compare so high address bits cannot alias into range.
    req_legal = size_aligned(req_size, req_addr[2:0]) && (req_addr < AddrLimit);
    case (state_q)
      IDLE:    if (accept) state_d = req_legal ? ISSUE : RESP;
      ISSUE:   state_d = RESP;
      RESP: begin
        if (resp_ready) state_d = accept ? (req_legal ? ISSUE : RESP) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Derived from state so an asynchronous reset withdraws a store immediately.
  always_comb begin
    mem_store_type = NO_STORE;
    if (state_q == ISSUE && is_store_q) mem_store_type = store_type_of(size_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      is_store_q    <= 1'b0;
      size_q        <= SIZE_BYTE;
      zero_ext_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      resp_rdata_q  <= '0;
      resp_fault_q  <= 1'b0;
      fault_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q <= req_is_store;
        size_q     <= req_size;
        zero_ext_q <= req_unsigned;
        if (req_legal) begin
          // mem_addr/mem_wdata only move for legal requests; faults leave memory untouched.
          mem_addr_q  <= req_addr;
          mem_wdata_q <= req_wdata;
        end else begin
          resp_rdata_q <= '0;
          resp_fault_q <= 1'b1;
          if (fault_count_q != 16'hFFFF) fault_count_q <= fault_count_q + 16'd1;
        end
      end
      if (state_q == ISSUE) begin
        resp_rdata_q <= is_store_q ? 64'd0 : ext_data;
        resp_fault_q <= 1'b0;
      end
    end
  end

  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = resp_rdata_q;
  assign resp_fault  = resp_fault_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign fault_count = fault_count_q;

endmodule
